// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: merges single-cycle ALU results and
// FIFO-buffered LSU results onto one write port, tracks pending LSU writes
// per register and forwards not-yet-committed values to two read ports.
module rf_writeback_ctrl #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_alu_valid,
   output logic            o_alu_ready,
   input  logic [4:0]      i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic            i_lsu_valid,
   output logic            o_lsu_ready,
   input  logic [4:0]      i_lsu_rd,
   input  logic [XLEN-1:0] i_lsu_data,
   output logic            o_Wen,
   output logic [4:0]      o_Wnum,
   output logic [XLEN-1:0] o_Wd,
   output logic [31:0]     o_busy,
   input  logic [4:0]      i_Rnum1,
   input  logic [4:0]      i_Rnum2,
   output logic            o_fwd1_hit,
   output logic            o_fwd2_hit,
   output logic [XLEN-1:0] o_fwd1_data,
   output logic [XLEN-1:0] o_fwd2_data
);

   localparam int unsigned RW   = 5;
   localparam int unsigned NREG = 32;
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned SW   = $clog2(STARVE_MAX + 1);

   // FIFO storage and pointers
   logic [RW-1:0]   fifo_rd_q   [DEPTH];
   logic [RW-1:0]   fifo_rd_d   [DEPTH];
   logic [XLEN-1:0] fifo_data_q [DEPTH];
   logic [XLEN-1:0] fifo_data_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic [SW-1:0]   starve_q, starve_d;

   // Write port and scoreboard
   logic            wen_q,  wen_d;
   logic [RW-1:0]   wnum_q, wnum_d;
   logic [XLEN-1:0] wd_q,   wd_d;
   logic [NREG-1:0] busy_q, busy_d;

   // Per-cycle selection
   logic            fifo_empty;
   logic            starve_hit;
   logic            alu_ready;
   logic            lsu_ready;
   logic            alu_take;
   logic            pop;
   logic            push;
   logic [RW-1:0]   head_rd;
   logic [XLEN-1:0] head_data;

   // Forwarding
   logic [DEPTH-1:0] ent_valid;
   logic [RW-1:0]    rnum       [2];
   logic [1:0]       fwd_hit_c;
   logic [XLEN-1:0]  fwd_data_c [2];

   // Arbitration: a starved head wins, then the ALU, then the head
   always_comb begin
      fifo_empty = (count_q == '0);
      starve_hit = !fifo_empty && (starve_q == SW'(STARVE_MAX));
      alu_ready  = !starve_hit;
      lsu_ready  = (count_q < CW'(DEPTH));
      alu_take   = i_alu_valid && alu_ready;
      pop        = !fifo_empty && (starve_hit || !i_alu_valid);
      push       = i_lsu_valid && lsu_ready && (i_lsu_rd != '0);
      head_rd    = fifo_rd_q[rd_ptr_q];
      head_data  = fifo_data_q[rd_ptr_q];
   end

   // Next-state: write port, FIFO, starve counter and pending-write scoreboard
   always_comb begin
      wen_d       = 1'b0;
      wnum_d      = wnum_q;
      wd_d        = wd_q;
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      starve_d    = starve_q;
      busy_d      = busy_q;

      if (pop) begin
         wen_d  = 1'b1;
         wnum_d = head_rd;
         wd_d   = head_data;
      end else if (alu_take && (i_alu_rd != '0)) begin
         wen_d  = 1'b1;
         wnum_d = i_alu_rd;
         wd_d   = i_alu_data;
      end

      if (push) begin
         fifo_rd_d[wr_ptr_q]   = i_lsu_rd;
         fifo_data_d[wr_ptr_q] = i_lsu_data;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end

      // Clear before set so a same-register pop+push leaves the bit set
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (push) begin
         busy_d[i_lsu_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         wen_q    <= 1'b0;
         wnum_q   <= '0;
         wd_q     <= '0;
         busy_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         wen_q    <= wen_d;
         wnum_q   <= wnum_d;
         wd_q     <= wd_d;
         busy_q   <= busy_d;
      end
   end

   // FIFO payload storage; validity is tracked by the pointers alone
   always_ff @(posedge i_clk) begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
   end

   // An entry is live when its distance from the read pointer is below count
   always_comb begin
      logic [PW-1:0] off;
      ent_valid = '0;
      off       = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         off          = PW'(i) - rd_ptr_q;
         ent_valid[i] = ({1'b0, off} < count_q);
      end
   end

   assign rnum[0] = i_Rnum1;
   assign rnum[1] = i_Rnum2;

   // Forwarding lookup: a queued entry overrides the in-flight output write
   always_comb begin
      fwd_hit_c  = '0;
      fwd_data_c = '{default: '0};
      for (int p = 0; p < 2; p++) begin
         if (rnum[p] != '0) begin
            if (wen_q && (wnum_q == rnum[p])) begin
               fwd_hit_c[p]  = 1'b1;
               fwd_data_c[p] = wd_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (ent_valid[i] && (fifo_rd_q[i] == rnum[p])) begin
                  fwd_hit_c[p]  = 1'b1;
                  fwd_data_c[p] = fifo_data_q[i];
               end
            end
         end
      end
   end

   assign o_alu_ready = alu_ready;
   assign o_lsu_ready = lsu_ready;
   assign o_Wen       = wen_q;
   assign o_Wnum      = wnum_q;
   assign o_Wd        = wd_q;
   assign o_busy      = busy_q;
   assign o_fwd1_hit  = fwd_hit_c[0];
   assign o_fwd2_hit  = fwd_hit_c[1];
   assign o_fwd1_data = fwd_data_c[0];
   assign o_fwd2_data = fwd_data_c[1];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rf_writeback_ctrl;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int          SM    = 3;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_alu_valid, o_alu_ready;
   logic [4:0]      i_alu_rd;
   logic [XLEN-1:0] i_alu_data;
   logic            i_lsu_valid, o_lsu_ready;
   logic [4:0]      i_lsu_rd;
   logic [XLEN-1:0] i_lsu_data;
   logic            o_Wen;
   logic [4:0]      o_Wnum;
   logic [XLEN-1:0] o_Wd;
   logic [31:0]     o_busy;
   logic [4:0]      i_Rnum1, i_Rnum2;
   logic            o_fwd1_hit, o_fwd2_hit;
   logic [XLEN-1:0] o_fwd1_data, o_fwd2_data;

   rf_writeback_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
      .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
      .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
      .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
      .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd), .o_busy(o_busy),
      .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2),
      .o_fwd1_hit(o_fwd1_hit), .o_fwd2_hit(o_fwd2_hit),
      .o_fwd1_data(o_fwd1_data), .o_fwd2_data(o_fwd2_data)
   );

   initial forever #5 i_clk = ~i_clk;

   typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
   typedef struct { int c; logic [4:0] n; logic [31:0] d; } wr_t;

   // Reference model state: the queue holds exactly the pending LSU writes
   ent_t        mq[$];
   int          mst;
   logic        mw;
   logic [4:0]  mwn;
   logic [31:0] mwd;
   bit          model_ok = 0;
   int          cyc = 0;
   bit          m_ne, m_starve, m_lrdy, m_pop;
   ent_t        m_h, m_e;
   logic [31:0] m_busy;
   logic [32:0] f1, f2;

   // Observation logs
   int  lsu_acc[$];
   wr_t wlog[$];
   wr_t lw[$];
   int  alu_low = 0;
   int  checks = 0, failures = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [32:0] mfwd(input logic [4:0] r);
      if (r == 5'd0) return '0;
      foreach (mq[k]) if (mq[k].rd == r) return {1'b1, mq[k].data};
      if (mw && mwn == r) return {1'b1, mwd};
      return '0;
   endfunction

   // Model update on each rising edge from the inputs present at that edge
   initial forever begin
      @(posedge i_clk);
      cyc++;
      if (!i_rst_n) begin
         mq.delete(); mst = 0; mw = 0; mwn = '0; mwd = '0; model_ok = 1;
      end else if (model_ok) begin
         m_ne     = (mq.size() > 0);
         m_starve = m_ne && (mst == SM);
         m_lrdy   = (mq.size() < DEPTH);
         m_pop    = 0;
         if (m_starve || (m_ne && !i_alu_valid)) begin
            m_h = mq.pop_front(); mw = 1; mwn = m_h.rd; mwd = m_h.data; m_pop = 1;
         end else if (i_alu_valid && i_alu_rd != 5'd0) begin
            mw = 1; mwn = i_alu_rd; mwd = i_alu_data;
         end else begin
            mw = 0;
         end
         if (!m_ne || m_pop) mst = 0;
         else if (mst < SM) mst++;
         if (i_lsu_valid && m_lrdy) begin
            lsu_acc.push_back(cyc);
            if (i_lsu_rd != 5'd0) begin
               m_e.rd = i_lsu_rd; m_e.data = i_lsu_data; mq.push_back(m_e);
            end
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle
   initial forever begin
      @(negedge i_clk);
      if (model_ok) begin
         m_busy = '0;
         foreach (mq[k]) m_busy[mq[k].rd] = 1'b1;
         f1 = mfwd(i_Rnum1);
         f2 = mfwd(i_Rnum2);
         check("alu_ready", o_alu_ready, !(mq.size() > 0 && mst == SM));
         check("lsu_ready", o_lsu_ready, mq.size() < DEPTH);
         check("wen", o_Wen, mw);
         check("wnum", o_Wnum, mwn);
         check("wd", o_Wd, mwd);
         check("busy", o_busy, m_busy);
         check("fwd1_hit", o_fwd1_hit, f1[32]);
         check("fwd1_data", o_fwd1_data, f1[31:0]);
         check("fwd2_hit", o_fwd2_hit, f2[32]);
         check("fwd2_data", o_fwd2_data, f2[31:0]);
         if (i_alu_valid && i_alu_rd != 5'd0 && m_busy[i_alu_rd]) begin
            failures++; $display("FAIL contract_alu rd=%0d busy", i_alu_rd);
         end
         if (i_lsu_valid && i_lsu_rd != 5'd0 && m_busy[i_lsu_rd]) begin
            failures++; $display("FAIL contract_lsu rd=%0d busy", i_lsu_rd);
         end
         if (!o_alu_ready) alu_low++;
         if (o_Wen === 1'b1) wlog.push_back('{c: cyc, n: o_Wnum, d: o_Wd});
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Hold an ALU result until it is accepted; caller drops valid afterwards
   task automatic alu_send(input logic [4:0] rd, input logic [31:0] d);
      int n; logic r;
      i_alu_valid = 1'b1; i_alu_rd = rd; i_alu_data = d; n = 0;
      do begin @(negedge i_clk); r = o_alu_ready; tick(); n++; end while (!r && n < 40);
      if (!r) begin checks++; failures++; $display("FAIL alu_send_timeout rd=%0d", rd); end
   endtask

   task automatic lsu_send(input logic [4:0] rd, input logic [31:0] d);
      int n; logic r;
      i_lsu_valid = 1'b1; i_lsu_rd = rd; i_lsu_data = d; n = 0;
      do begin @(negedge i_clk); r = o_lsu_ready; tick(); n++; end while (!r && n < 40);
      if (!r) begin checks++; failures++; $display("FAIL lsu_send_timeout rd=%0d", rd); end
   endtask

   int st_n[7] = '{10, 11, 12, 13, 7, 14, 15};
   int fl_acc[5] = '{0, 1, 2, 3, 5};
   int fl_wr[5]  = '{4, 8, 12, 13, 14};
   int base;

   initial begin
      i_rst_n = 1'b0; i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
      i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0; i_Rnum1 = '0; i_Rnum2 = '0;
      idle(2);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rst_wen", o_Wen, 0); check("rst_wnum", o_Wnum, 0); check("rst_wd", o_Wd, 0);
      check("rst_busy", o_busy, 0); check("rst_alu_rdy", o_alu_ready, 1);
      check("rst_lsu_rdy", o_lsu_ready, 1);
      tick();

      // Single ALU write with read-port forwarding from the output register
      i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF; i_Rnum1 = 5'd5;
      @(negedge i_clk); check("t1_alu_rdy", o_alu_ready, 1);
      tick(); i_alu_valid = 0;
      @(negedge i_clk);
      check("t1_wen", o_Wen, 1); check("t1_wnum", o_Wnum, 5); check("t1_wd", o_Wd, 32'hDEADBEEF);
      check("t1_fwd1_hit", o_fwd1_hit, 1); check("t1_fwd1_data", o_fwd1_data, 32'hDEADBEEF);
      tick();
      @(negedge i_clk);
      check("t1_wen_off", o_Wen, 0); check("t1_wnum_hold", o_Wnum, 5);
      check("t1_fwd1_off", o_fwd1_hit, 0);

      // Starvation: one LSU result behind a continuous ALU stream
      idle(2); wlog.delete(); lsu_acc.delete(); alu_low = 0; i_Rnum1 = 5'd7; i_Rnum2 = 5'd12;
      fork
         begin lsu_send(5'd7, 32'h77770007); i_lsu_valid = 0; end
         begin
            for (int k = 0; k < 6; k++) alu_send(5'(10 + k), 32'hA0A00000 + 32'(k));
            i_alu_valid = 0;
         end
      join
      idle(3);
      check("st_alu_low", alu_low, 1);
      check("st_nwr", wlog.size(), 7);
      base = (lsu_acc.size() > 0) ? lsu_acc[0] : 0;
      for (int i = 0; i < 7 && i < wlog.size(); i++) begin
         check($sformatf("st_wnum%0d", i), wlog[i].n, st_n[i]);
         check($sformatf("st_wcyc%0d", i), wlog[i].c - base, i);
      end
      if (wlog.size() > 4) check("st_x7_data", wlog[4].d, 32'h77770007);

      // Fill the FIFO under ALU pressure, then drain in order
      idle(2); wlog.delete(); lsu_acc.delete(); alu_low = 0; i_Rnum1 = 5'd3; i_Rnum2 = 5'd22;
      fork
         begin
            for (int i = 1; i <= 5; i++) lsu_send(5'(i), 32'h1000 + 32'(i));
            i_lsu_valid = 0;
         end
         begin
            for (int k = 0; k < 10; k++) alu_send(5'(20 + k), 32'hB0000000 + 32'(k));
            i_alu_valid = 0;
         end
      join
      idle(5);
      check("fl_nacc", lsu_acc.size(), 5);
      base = (lsu_acc.size() > 0) ? lsu_acc[0] : 0;
      for (int i = 0; i < 5 && i < lsu_acc.size(); i++)
         check($sformatf("fl_acc%0d", i), lsu_acc[i] - base, fl_acc[i]);
      lw.delete();
      foreach (wlog[k]) if (wlog[k].n >= 5'd1 && wlog[k].n <= 5'd5) lw.push_back(wlog[k]);
      check("fl_nlsu_wr", lw.size(), 5);
      for (int i = 0; i < 5 && i < lw.size(); i++) begin
         check($sformatf("fl_wnum%0d", i), lw[i].n, i + 1);
         check($sformatf("fl_wd%0d", i), lw[i].d, 32'h1000 + 32'(i + 1));
         check($sformatf("fl_wcyc%0d", i), lw[i].c - base, fl_wr[i]);
      end
      check("fl_alu_low", alu_low, 3);
      @(negedge i_clk); check("fl_busy_end", o_busy, 0);
      tick();

      // x0 results: both handshakes complete, nothing is written or queued
      idle(2); wlog.delete(); lsu_acc.delete();
      i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 32'h55;
      i_lsu_valid = 1; i_lsu_rd = 5'd0; i_lsu_data = 32'h66;
      @(negedge i_clk);
      check("x0_alu_rdy", o_alu_ready, 1); check("x0_lsu_rdy", o_lsu_ready, 1);
      tick(); i_alu_valid = 0; i_lsu_valid = 0;
      @(negedge i_clk);
      check("x0_wen", o_Wen, 0); check("x0_busy", o_busy, 0); check("x0_lsu_hs", lsu_acc.size(), 1);
      idle(3);
      check("x0_nwr", wlog.size(), 0);

      // Forwarding: queued entry beats the output register for the same rd
      idle(2); i_Rnum1 = 5'd0; i_Rnum2 = 5'd9;
      i_alu_valid = 1; i_alu_rd = 5'd9; i_alu_data = 32'hAAAA0009;
      i_lsu_valid = 1; i_lsu_rd = 5'd9; i_lsu_data = 32'hBBBB0009;
      tick(); i_alu_valid = 0; i_lsu_valid = 0;
      @(negedge i_clk);
      check("fw_wd_alu", o_Wd, 32'hAAAA0009); check("fw_busy", o_busy, 32'h200);
      check("fw_hit_q", o_fwd2_hit, 1); check("fw_data_q", o_fwd2_data, 32'hBBBB0009);
      check("fw_x0_miss", o_fwd1_hit, 0);
      tick();
      @(negedge i_clk);
      check("fw_wd_lsu", o_Wd, 32'hBBBB0009); check("fw_busy_clr", o_busy, 0);
      check("fw_hit_w", o_fwd2_hit, 1); check("fw_data_w", o_fwd2_data, 32'hBBBB0009);
      tick();
      @(negedge i_clk);
      check("fw_miss", o_fwd2_hit, 0); check("fw_miss_data", o_fwd2_data, 0);
      tick();

      // Mid-operation reset discards three queued LSU results
      idle(2); i_Rnum1 = 5'd11; i_Rnum2 = 5'd13;
      for (int k = 0; k < 3; k++) begin
         i_lsu_valid = 1; i_lsu_rd = 5'(11 + k); i_lsu_data = 32'hC000 + 32'(k);
         i_alu_valid = 1; i_alu_rd = 5'(20 + k); i_alu_data = 32'hD000 + 32'(k);
         tick();
      end
      i_lsu_valid = 0; i_alu_valid = 0; i_rst_n = 0;
      @(negedge i_clk); check("rs_busy_pre", o_busy, 32'h3800);
      tick(); i_rst_n = 1;
      @(negedge i_clk);
      check("rs_busy", o_busy, 0); check("rs_lsu_rdy", o_lsu_ready, 1);
      check("rs_wen", o_Wen, 0); check("rs_fwd_hit", o_fwd2_hit, 0);
      wlog.delete();
      idle(6);
      check("rs_nwr", wlog.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
